// File: rtl/axis_fifo_pkg.sv
// Shared constants, pointer-width helper and beat layout for the AXI4-Stream FIFO family.
package axis_fifo_pkg;

    localparam int AXIS_DATA_WIDTH_DEF = 64;
    localparam int AXIS_DEPTH_DEF      = 16;

    // One extra bit beyond the address lets equal addresses mean either full or empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [AXIS_DATA_WIDTH_DEF-1:0]   tdata;
        logic [AXIS_DATA_WIDTH_DEF/8-1:0] tkeep;
        logic                             tlast;
    } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI4-Stream beat channel; master drives the payload, slave drives tready.
interface axis_sync_fifo_if
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH_DEF
) ();
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Register-array storage: synchronous write port, asynchronous read port.
module axis_fifo_ram #(
    parameter int WIDTH  = 73,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; pointers alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO, first-word-fall-through, with occupancy and event flags.
// Define AXIS_SYNC_FIFO_PACKET_MODE_EN to gate output until a whole packet is stored.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
    parameter int DEPTH       = AXIS_DEPTH_DEF,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int PTR_W      = ptr_width(DEPTH)
) (
    input  logic             aclk,
    input  logic             areset,
    axis_sync_fifo_if.slave  s_axis,
    axis_sync_fifo_if.master m_axis,
    output logic [PTR_W-1:0] occupancy,
    output logic             axis_overflow,
    output logic             axis_underflow
);
    localparam int ADDR_W = PTR_W - 1;
    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic                  tlast;
    } beat_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, out_ok, wr_en, rd_en;
    beat_t            wr_beat, rd_beat;

    assign full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign occupancy = wr_ptr_q - rd_ptr_q;

    assign s_axis.tready = !full && !areset;
    assign wr_en         = s_axis.tvalid && s_axis.tready;
    assign m_axis.tvalid = !empty && out_ok;
    assign rd_en         = m_axis.tvalid && m_axis.tready;

    assign wr_beat = '{tdata: s_axis.tdata, tkeep: s_axis.tkeep, tlast: s_axis.tlast};

    axis_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_beat)
    );

    assign m_axis.tdata = m_axis.tvalid ? rd_beat.tdata : '0;
    assign m_axis.tkeep = m_axis.tvalid ? rd_beat.tkeep : '0;
    assign m_axis.tlast = m_axis.tvalid ? rd_beat.tlast : 1'b0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + (wr_en ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d    = rd_ptr_q + (rd_en ? PTR_W'(1) : PTR_W'(0));
        overflow_d  = s_axis.tvalid && !s_axis.tready;
        underflow_d = m_axis.tready && !m_axis.tvalid;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign axis_overflow  = overflow_q;
    assign axis_underflow = underflow_q;

`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
    logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             release_q, release_d;
    logic             pkt_in, pkt_out;

    assign pkt_in  = wr_en && s_axis.tlast;
    assign pkt_out = rd_en && m_axis.tlast;

    // Release lets an over-long packet stream out once it has filled the buffer.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        release_d = release_q;
        if (pkt_in && !pkt_out) begin
            pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
        end else if (!pkt_in && pkt_out) begin
            pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
        end
        if (pkt_out) begin
            release_d = 1'b0;
        end else if (full && (pkt_cnt_q == '0)) begin
            release_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q <= '0;
            release_q <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            release_q <= release_d;
        end
    end

    assign out_ok = (pkt_cnt_q != '0) || release_q;
`else
    assign out_ok = 1'b1;
`endif
endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed, table-driven bench for axis_sync_fifo at DATA_WIDTH=64, DEPTH=16.
module tb_axis_sync_fifo;
    import axis_fifo_pkg::*;

`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic       aclk = 1'b0;
    logic       areset;
    logic [4:0] occupancy;
    logic       axis_overflow, axis_underflow;
    int         checks = 0;
    int         failures = 0;

    axis_sync_fifo_if #(.DATA_WIDTH(64)) s_if ();
    axis_sync_fifo_if #(.DATA_WIDTH(64)) m_if ();

    axis_sync_fifo #(.DATA_WIDTH(64), .DEPTH(16)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .occupancy      (occupancy),
        .axis_overflow  (axis_overflow),
        .axis_underflow (axis_underflow)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       sv;
        axis_beat_t beat;
        logic       mr;
        logic       e_sready;
        logic       e_mvalid;
        axis_beat_t e_beat;
        int         e_occ;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic sv, input axis_beat_t b, input logic mr,
                                input logic e_sr, input logic e_mv, input axis_beat_t e_b,
                                input int e_occ, input logic e_ovf, input logic e_unf);
        vec_t v;
        v = '{sv: sv, beat: b, mr: mr, e_sready: e_sr, e_mvalid: e_mv, e_beat: e_b,
              e_occ: e_occ, e_ovf: e_ovf, e_unf: e_unf};
        return v;
    endfunction

    function automatic axis_beat_t mk_beat(input int i, input logic last);
        axis_beat_t b;
        b.tdata = 64'hC0DE_0000_0000_0000 | 64'(i);
        b.tkeep = 8'(i * 3 + 1);
        b.tlast = last;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input axis_beat_t b, input logic mr);
        s_if.tvalid = sv;
        s_if.tdata  = b.tdata;
        s_if.tkeep  = b.tkeep;
        s_if.tlast  = b.tlast;
        m_if.tready = mr;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        @(negedge aclk);
    endtask

    task automatic check_beat(input string name, input axis_beat_t exp);
        check({name, "_data"}, m_if.tdata, exp.tdata);
        check({name, "_keep"}, 64'(m_if.tkeep), 64'(exp.tkeep));
        check({name, "_last"}, 64'(m_if.tlast), 64'(exp.tlast));
    endtask

    // Consume up to n beats with tready held high, comparing against mk_beat(base+k).
    task automatic drain(input string name, input int base, input int n, input int last_idx);
        int got = 0;
        drive(1'b0, '0, 1'b1);
        for (int c = 0; c < 4 * n + 8 && got < n; c++) begin
            settle();
            if (m_if.tvalid) begin
                check_beat($sformatf("%s%0d", name, got), mk_beat(base + got, got == last_idx));
                got++;
            end
            tick();
        end
        check({name, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_beat_t b0, bF, b1, b2, b3, b4, bx1;
        logic       mvx;
        int         sent, got;
        logic       saw_full;

        b0  = '0;
        bF  = '{tdata: 64'hFFFF_FFFF_FFFF_FFFF, tkeep: 8'hCF, tlast: 1'b1};
        b1  = '{tdata: 64'h1111_1111_1111_1111, tkeep: 8'hFF, tlast: 1'b0};
        b2  = '{tdata: 64'h2222_2222_2222_2222, tkeep: 8'hFF, tlast: 1'b0};
        b3  = '{tdata: 64'h3333_3333_3333_3333, tkeep: 8'hFF, tlast: 1'b0};
        b4  = '{tdata: 64'h4444_4444_4444_4444, tkeep: 8'hFF, tlast: 1'b1};
        bx1 = PKT ? b0 : b1;
        mvx = !PKT;

        vecs[0]  = mk(0, b0, 0, 1, 0,   b0,  0, 0, 0);
        vecs[1]  = mk(1, bF, 0, 1, 0,   b0,  0, 0, 0);
        vecs[2]  = mk(0, b0, 0, 1, 1,   bF,  1, 0, 0);
        vecs[3]  = mk(0, b0, 1, 1, 1,   bF,  1, 0, 0);
        vecs[4]  = mk(0, b0, 0, 1, 0,   b0,  0, 0, 0);
        vecs[5]  = mk(1, b1, 0, 1, 0,   b0,  0, 0, 0);
        vecs[6]  = mk(1, b2, 0, 1, mvx, bx1, 1, 0, 0);
        vecs[7]  = mk(1, b3, 0, 1, mvx, bx1, 2, 0, 0);
        vecs[8]  = mk(1, b4, 0, 1, mvx, bx1, 3, 0, 0);
        vecs[9]  = mk(0, b0, 0, 1, 1,   b1,  4, 0, 0);
        vecs[10] = mk(0, b0, 1, 1, 1,   b1,  4, 0, 0);
        vecs[11] = mk(0, b0, 1, 1, 1,   b2,  3, 0, 0);
        vecs[12] = mk(0, b0, 1, 1, 1,   b3,  2, 0, 0);
        vecs[13] = mk(0, b0, 1, 1, 1,   b4,  1, 0, 0);
        vecs[14] = mk(0, b0, 1, 1, 0,   b0,  0, 0, 0);
        vecs[15] = mk(0, b0, 1, 1, 0,   b0,  0, 0, 1);
        vecs[16] = mk(0, b0, 0, 1, 0,   b0,  0, 0, 1);
        vecs[17] = mk(0, b0, 0, 1, 0,   b0,  0, 0, 0);

        // Reset state.
        areset = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        settle();
        check("rst_sready", 64'(s_if.tready), 64'd0);
        check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_tdata", m_if.tdata, 64'd0);
        check("rst_ovf", 64'(axis_overflow), 64'd0);
        check("rst_unf", 64'(axis_underflow), 64'd0);
        tick();
        areset = 1'b0;

        // Single beat, four-beat burst, underflow.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].sv, vecs[i].beat, vecs[i].mr);
            settle();
            check($sformatf("v%0d_sready", i), 64'(s_if.tready), 64'(vecs[i].e_sready));
            check($sformatf("v%0d_mvalid", i), 64'(m_if.tvalid), 64'(vecs[i].e_mvalid));
            check_beat($sformatf("v%0d", i), vecs[i].e_beat);
            check($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
            check($sformatf("v%0d_ovf", i), 64'(axis_overflow), 64'(vecs[i].e_ovf));
            check($sformatf("v%0d_unf", i), 64'(axis_underflow), 64'(vecs[i].e_unf));
            tick();
        end

        // Fill to 16, hold a 17th beat, then read+write at 15 and drain.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, mk_beat(i, 1'b1), 1'b0);
            settle();
            check($sformatf("fill%0d_sready", i), 64'(s_if.tready), 64'd1);
            check($sformatf("fill%0d_occ", i), 64'(occupancy), 64'(i));
            tick();
        end
        drive(1'b1, mk_beat(16, 1'b1), 1'b0);
        settle();
        check("full_sready", 64'(s_if.tready), 64'd0);
        check("full_occ", 64'(occupancy), 64'd16);
        check("full_ovf0", 64'(axis_overflow), 64'd0);
        tick();
        settle();
        check("full_ovf1", 64'(axis_overflow), 64'd1);
        check("full_occ_hold", 64'(occupancy), 64'd16);
        tick();
        drive(1'b0, '0, 1'b0);
        settle();
        check("full_ovf2", 64'(axis_overflow), 64'd1);
        tick();
        settle();
        check("full_ovf_clear", 64'(axis_overflow), 64'd0);
        check("full_occ_end", 64'(occupancy), 64'd16);
        tick();
        drive(1'b0, '0, 1'b1);
        settle();
        check_beat("full_head", mk_beat(0, 1'b1));
        tick();
        drive(1'b1, mk_beat(100, 1'b1), 1'b1);
        settle();
        check("rw_sready", 64'(s_if.tready), 64'd1);
        check("rw_occ_before", 64'(occupancy), 64'd15);
        check_beat("rw_head", mk_beat(1, 1'b1));
        tick();
        drive(1'b0, '0, 1'b0);
        settle();
        check("rw_occ_after", 64'(occupancy), 64'd15);
        tick();
        drive(1'b0, '0, 1'b1);
        for (int j = 0; j < 15; j++) begin
            settle();
            check($sformatf("drain%0d_mvalid", j), 64'(m_if.tvalid), 64'd1);
            check_beat($sformatf("drain%0d", j), mk_beat(j < 14 ? j + 2 : 100, 1'b1));
            tick();
        end
        settle();
        check("drain_occ", 64'(occupancy), 64'd0);
        check("drain_mvalid", 64'(m_if.tvalid), 64'd0);
        tick();

`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
        // Packet held until its tlast beat is stored.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk_beat(400 + i, i == 3), 1'b0);
            settle();
            check($sformatf("pk_hold%0d", i), 64'(m_if.tvalid), 64'd0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        settle();
        check("pk_release_valid", 64'(m_if.tvalid), 64'd1);
        check_beat("pk_head", mk_beat(400, 1'b0));
        tick();
        drain("pk4_", 400, 4, 3);

        // 20-beat packet fills the buffer, release opens the output.
        sent = 0;
        got = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            drive(sent < 20, mk_beat(300 + sent, sent == 19), 1'b1);
            settle();
            if (sent < 16) check($sformatf("pk20_hold%0d", sent), 64'(m_if.tvalid), 64'd0);
            if (!s_if.tready) saw_full = 1'b1;
            if (m_if.tvalid) begin
                check_beat($sformatf("pk20_%0d", got), mk_beat(300 + got, got == 19));
                got++;
            end
            if (s_if.tvalid && s_if.tready) sent++;
            tick();
        end
        check("pk20_count", 64'(got), 64'd20);
        check("pk20_saw_full", 64'(saw_full), 64'd1);
        drive(1'b0, '0, 1'b0);
        settle();
        check("pk20_empty", 64'(occupancy), 64'd0);
        tick();
`endif

        // Reset with five beats of an unfinished packet stored.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk_beat(200 + i, 1'b0), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        settle();
        check("mid_occ5", 64'(occupancy), 64'd5);
        tick();
        areset = 1'b1;
        settle();
        check("mid_rst_sready", 64'(s_if.tready), 64'd0);
        tick();
        areset = 1'b0;
        settle();
        check("mid_occ", 64'(occupancy), 64'd0);
        check("mid_mvalid", 64'(m_if.tvalid), 64'd0);
        check("mid_sready", 64'(s_if.tready), 64'd1);
        check("mid_tdata", m_if.tdata, 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk_beat(210 + i, i == 2), 1'b0);
            tick();
        end
        drain("post_", 210, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Parametrised single-clock AXI4-Stream FIFO carrying tdata/tkeep/tlast, with occupancy reporting, overflow/underflow event flags and an optional store-and-forward packet mode. It replaces the fixed 64-bit generated FIFO core in single-clock-domain paths. It sits between a stream producer (e.g. MAC receive path) and a consumer (e.g. packet parser).

## Interface
- DATA_WIDTH, 64, tdata width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; fixed by DATA_WIDTH, not overridden.
- DEPTH, 16, storage entries; power of two, ≥ 2.
- aclk  in  1  sole clock; everything is rising-edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  producer beat valid.
- s_axis_tready  out  1  FIFO can accept a beat.
- s_axis_tdata  in  DATA_WIDTH  beat data.
- s_axis_tkeep  in  KEEP_WIDTH  byte-valid mask; stored verbatim, never interpreted.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tdata  out  DATA_WIDTH  head-of-queue data.
- m_axis_tkeep  out  KEEP_WIDTH  head-of-queue keep.
- m_axis_tlast  out  1  head-of-queue last.
- occupancy  out  $clog2(DEPTH)+1  beats currently stored, 0..DEPTH.
- axis_overflow  out  1  one-cycle event: s_axis_tvalid high while s_axis_tready low.
- axis_underflow  out  1  one-cycle event: m_axis_tready high while m_axis_tvalid low.

## Operation
- Circular buffer: write and read pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Wrap from DEPTH-1 to 0 is natural modulo.
- Write: beat accepted on an edge with s_axis_tvalid && s_axis_tready. s_axis_tready = !full && !areset; it does not depend on m_axis_tready, so a full FIFO does not accept a beat even when it is read in the same cycle.
- Read: beat consumed on an edge with m_axis_tvalid && m_axis_tready. Output is first-word-fall-through: the head entry is presented directly.
- m_axis_tdata/tkeep/tlast are forced to zero whenever m_axis_tvalid is low.
- Simultaneous accept and consume: both pointers advance and occupancy is unchanged.
- Order of tdata/tkeep/tlast is preserved exactly. No beat is ever dropped or duplicated.
- Overflow/underflow flags are observational only. They do not alter state and are registered, so they assert the cycle after the condition.

## Timing
- Reset (any cycle, including mid-packet): pointers, occupancy, packet counter and release flag clear on the edge.
- Reset values: s_axis_tready 0 while areset is high, 1 in the first cycle after areset falls. m_axis_tvalid 0. Output data 0. occupancy 0. Both event flags 0.
- Write-to-output latency: a beat accepted at edge k drives m_axis_tvalid high immediately after edge k when the FIFO was empty (cut-through mode).
- occupancy updates on the same edge as the accept or consume.
- Full: occupancy == DEPTH and s_axis_tready is 0. Empty: occupancy == 0 and m_axis_tvalid is 0.
- Sustained throughput: one beat per cycle when both sides are continuously ready.

## Configuration
- AXIS_SYNC_FIFO_PACKET_MODE_EN defined: store-and-forward mode.
  - A packet counter increments on an accepted tlast beat and decrements on a consumed tlast beat; when both occur together it is unchanged.
  - m_axis_tvalid = !empty && (pkt_count != 0 || release).
  - release sets when full && pkt_count == 0, so a packet longer than DEPTH does not deadlock. It clears on the consumed tlast beat.
  - Output latency for a single beat with tlast is the same as cut-through mode.
  - A packet without tlast is held until its tlast beat arrives or release sets.
- AXIS_SYNC_FIFO_PACKET_MODE_EN undefined: pure cut-through; no packet counter or release logic is synthesised.

## Structure
- Package axis_fifo_pkg holds:
  - the default DATA_WIDTH and DEPTH constants;
  - a localparam function for pointer width;
  - the packed beat struct (tdata, tkeep, tlast), shared with future async and width-converter variants.
- One sub-module, axis_fifo_ram: DEPTH x (DATA_WIDTH+KEEP_WIDTH+1) register array with a synchronous write port and an asynchronous read port.
- Pointer, flag and packet logic live in axis_sync_fifo.

## Test plan
- Reset, then write one beat 0xFFFF_FFFF_FFFF_FFFF, keep 0xCF, tlast 1 -> m_axis_tvalid high the next cycle with identical fields. occupancy 1, then 0 after consume.
- Write 0x1111…, 0x2222…, 0x3333…, 0x4444… (keep 0xFF, tlast on the 4th) with m_axis_tready 0 -> occupancy reaches 4. Release tready -> the same four beats in order, tlast only on 0x4444….
- DEPTH=16: write 17 beats with tready low -> s_axis_tready drops after 16, axis_overflow pulses while tvalid is held, occupancy stays 16. Simultaneous read+write at 15 entries -> occupancy stays 15.
- Hold m_axis_tready high on an empty FIFO -> axis_underflow high each cycle, m_axis_tdata 0.
- With AXIS_SYNC_FIFO_PACKET_MODE_EN: 3 beats without tlast -> m_axis_tvalid stays 0; 4th beat with tlast -> valid next cycle. A 20-beat packet at DEPTH=16 -> release at full and all 20 beats delivered.
- Assert areset mid-packet with 5 beats stored -> next cycle occupancy 0 and m_axis_tvalid 0. The new packet after reset is delivered intact.
